// File: rtl/fir_err_pkg.sv
// Shared types, default widths and the saturating-add helper for the FIR error monitor.
package fir_err_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ER_THRESH_DEF = 8;
  localparam int CNT_W_DEF     = 32;
  localparam int ACC_W_DEF     = 64;
  localparam int SAT_MAX_W     = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Unsigned a + b clamped to 2^w - 1; operands must already be below 2^w and w <= SAT_MAX_W.
  function automatic logic [SAT_MAX_W-1:0] sat_add(input logic [SAT_MAX_W-1:0] a,
                                                    input logic [SAT_MAX_W-1:0] b,
                                                    input int unsigned          w);
    logic [SAT_MAX_W:0] sum;
    logic [SAT_MAX_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ((SAT_MAX_W+1)'(1) << w) - (SAT_MAX_W+1)'(1);
    if (sum > lim) return lim[SAT_MAX_W-1:0];
    return sum[SAT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/fir_err_diff.sv
// Stage-1 register: per-sample error, magnitudes and match flags, captured on an accepted beat.
module fir_err_diff
  import fir_err_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ER_THRESH = ER_THRESH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_i,
  input  logic [DATA_W-1:0]        appr_i,
  input  logic [DATA_W-1:0]        accu_i,
  output logic                     valid_o,
  output logic signed [DATA_W:0]   e_o,
  output logic [DATA_W:0]          abs_e_o,
  output logic [DATA_W-1:0]        abs_accu_o,
  output logic                     eq_full_o,
  output logic                     eq_hi_o
);

  logic signed [DATA_W:0] e_d;
  logic [DATA_W:0]        abs_e_d;
  logic [DATA_W-1:0]      abs_accu_d;
  logic                   eq_full_d;
  logic                   eq_hi_d;

  logic                   valid_q;
  logic signed [DATA_W:0] e_q;
  logic [DATA_W:0]        abs_e_q;
  logic [DATA_W-1:0]      abs_accu_q;
  logic                   eq_full_q;
  logic                   eq_hi_q;

  // One extra bit holds any difference of two DATA_W-bit signed values, and |accu|
  // of the most-negative input (2^(DATA_W-1)) still fits DATA_W unsigned bits.
  always_comb begin
    e_d        = {appr_i[DATA_W-1], appr_i} - {accu_i[DATA_W-1], accu_i};
    abs_e_d    = e_d[DATA_W] ? -e_d : e_d;
    abs_accu_d = accu_i[DATA_W-1] ? -accu_i : accu_i;
    eq_full_d  = (appr_i == accu_i);
    eq_hi_d    = (appr_i[DATA_W-1:ER_THRESH] == accu_i[DATA_W-1:ER_THRESH]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      e_q        <= '0;
      abs_e_q    <= '0;
      abs_accu_q <= '0;
      eq_full_q  <= 1'b0;
      eq_hi_q    <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        e_q        <= e_d;
        abs_e_q    <= abs_e_d;
        abs_accu_q <= abs_accu_d;
        eq_full_q  <= eq_full_d;
        eq_hi_q    <= eq_hi_d;
      end
    end
  end

  assign valid_o    = valid_q;
  assign e_o        = e_q;
  assign abs_e_o    = abs_e_q;
  assign abs_accu_o = abs_accu_q;
  assign eq_full_o  = eq_full_q;
  assign eq_hi_o    = eq_hi_q;

endmodule

// File: rtl/fir_err_monitor.sv
// Error-statistics stage for the approximate/accurate FIR pair: run FSM, sample counters and
// stage-2 accumulators fed by the fir_err_diff stage-1 register.
module fir_err_monitor
  import fir_err_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ER_THRESH = ER_THRESH_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int ACC_W     = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  test_len_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] appr_i,
  input  logic [DATA_W-1:0] accu_i,
  output logic              done_o,
  output logic [CNT_W-1:0]  n_samples_o,
  output logic [ACC_W-1:0]  err_sum_o,
  output logic [ACC_W-1:0]  sq_err_sum_o,
  output logic [ACC_W-1:0]  abs_sum_o,
  output logic [CNT_W-1:0]  n_exact_o,
  output logic [CNT_W-1:0]  n_hi_match_o,
  output logic [DATA_W:0]   max_abs_err_o
);

  localparam int SQ_W = 2 * (DATA_W + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start_take;
  logic              accept;
  logic              last_accept;

  logic                   s1_valid;
  logic signed [DATA_W:0] s1_e;
  logic [DATA_W:0]        s1_abs_e;
  logic [DATA_W-1:0]      s1_abs_accu;
  logic                   s1_eq_full;
  logic                   s1_eq_hi;

  logic [SQ_W-1:0]   sq_full;
  logic [ACC_W-1:0]  sq_clamp;

  logic [ACC_W-1:0]  err_sum_q, err_sum_d;
  logic [ACC_W-1:0]  sq_sum_q, sq_sum_d;
  logic [ACC_W-1:0]  abs_sum_q, abs_sum_d;
  logic [CNT_W-1:0]  n_exact_q, n_exact_d;
  logic [CNT_W-1:0]  n_hi_q, n_hi_d;
  logic [DATA_W:0]   max_q, max_d;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // DRAIN covers the cycle the last sample sits in stage 1; stats are final when DONE is entered.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start_take) state_d = (test_len_i == '0) ? DONE : RUN;
      RUN:        if (last_accept) state_d = DRAIN;
      DRAIN:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready_o  = (state_q == RUN) && (cnt_q < len_q);
    done_o      = (state_q == DONE);
    start_take  = start_i && ((state_q == IDLE) || (state_q == DONE));
    accept      = in_valid_i && in_ready_o;
    last_accept = accept && ((cnt_q + CNT_W'(1)) == len_q);
  end

  // ---------------- run length and accepted-sample counters ----------------
  always_comb begin
    len_d = len_q;
    cnt_d = cnt_q;
    if (start_take) begin
      len_d = test_len_i;
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  end

  // ---------------- stage 1 ----------------
  fir_err_diff #(
    .DATA_W    (DATA_W),
    .ER_THRESH (ER_THRESH)
  ) u_diff (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (accept),
    .appr_i     (appr_i),
    .accu_i     (accu_i),
    .valid_o    (s1_valid),
    .e_o        (s1_e),
    .abs_e_o    (s1_abs_e),
    .abs_accu_o (s1_abs_accu),
    .eq_full_o  (s1_eq_full),
    .eq_hi_o    (s1_eq_hi)
  );

  // ---------------- stage 2 ----------------
  assign sq_full = SQ_W'(s1_abs_e) * SQ_W'(s1_abs_e);

  // A square that does not fit ACC_W bits already means the sum is pinned at full scale.
  if (SQ_W > ACC_W) begin : g_sq_clamp
    assign sq_clamp = (|sq_full[SQ_W-1:ACC_W]) ? '1 : sq_full[ACC_W-1:0];
  end else begin : g_sq_pass
    assign sq_clamp = ACC_W'(sq_full);
  end

  // NOTE: every variable gets a default at the top of a combinational block so no latch is inferred.
  always_comb begin
    err_sum_d = err_sum_q;
    sq_sum_d  = sq_sum_q;
    abs_sum_d = abs_sum_q;
    n_exact_d = n_exact_q;
    n_hi_d    = n_hi_q;
    max_d     = max_q;
    if (start_take) begin
      err_sum_d = '0;
      sq_sum_d  = '0;
      abs_sum_d = '0;
      n_exact_d = '0;
      n_hi_d    = '0;
      max_d     = '0;
    end else if (s1_valid) begin
      err_sum_d = err_sum_q + {{(ACC_W-DATA_W-1){s1_e[DATA_W]}}, s1_e};
      sq_sum_d  = ACC_W'(sat_add(SAT_MAX_W'(sq_sum_q), SAT_MAX_W'(sq_clamp), ACC_W));
      abs_sum_d = abs_sum_q + ACC_W'(s1_abs_accu);
      n_exact_d = n_exact_q + CNT_W'(s1_eq_full);
      n_hi_d    = n_hi_q + CNT_W'(s1_eq_hi);
      if (s1_abs_e > max_q) max_d = s1_abs_e;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sum_q <= '0;
      sq_sum_q  <= '0;
      abs_sum_q <= '0;
      n_exact_q <= '0;
      n_hi_q    <= '0;
      max_q     <= '0;
    end else begin
      err_sum_q <= err_sum_d;
      sq_sum_q  <= sq_sum_d;
      abs_sum_q <= abs_sum_d;
      n_exact_q <= n_exact_d;
      n_hi_q    <= n_hi_d;
      max_q     <= max_d;
    end
  end

  assign n_samples_o   = cnt_q;
  assign err_sum_o     = err_sum_q;
  assign sq_err_sum_o  = sq_sum_q;
  assign abs_sum_o     = abs_sum_q;
  assign n_exact_o     = n_exact_q;
  assign n_hi_match_o  = n_hi_q;
  assign max_abs_err_o = max_q;

endmodule

// File: tb/tb_fir_err_monitor.sv
// Directed bench for fir_err_monitor: a 64-bit and a 40-bit accumulator instance share stimulus;
// expected run statistics are queued as beats are driven and compared when done is seen.
module tb_fir_err_monitor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] test_len;
  logic        in_valid;
  logic [31:0] appr;
  logic [31:0] accu;

  logic        in_ready, done;
  logic [31:0] n_samples, n_exact, n_hi;
  logic [63:0] err_sum, sq_sum, abs_sum;
  logic [32:0] max_err;

  logic        in_ready_s, done_s;
  logic [31:0] n_samples_s, n_exact_s, n_hi_s;
  logic [39:0] err_sum_s, sq_sum_s, abs_sum_s;
  logic [32:0] max_err_s;

  fir_err_monitor #(.DATA_W(32), .ER_THRESH(8), .CNT_W(32), .ACC_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .test_len_i(test_len),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .appr_i(appr), .accu_i(accu),
    .done_o(done), .n_samples_o(n_samples), .err_sum_o(err_sum), .sq_err_sum_o(sq_sum),
    .abs_sum_o(abs_sum), .n_exact_o(n_exact), .n_hi_match_o(n_hi), .max_abs_err_o(max_err)
  );

  fir_err_monitor #(.DATA_W(32), .ER_THRESH(8), .CNT_W(32), .ACC_W(40)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start_i(start), .test_len_i(test_len),
    .in_valid_i(in_valid), .in_ready_o(in_ready_s), .appr_i(appr), .accu_i(accu),
    .done_o(done_s), .n_samples_o(n_samples_s), .err_sum_o(err_sum_s), .sq_err_sum_o(sq_sum_s),
    .abs_sum_o(abs_sum_s), .n_exact_o(n_exact_s), .n_hi_match_o(n_hi_s), .max_abs_err_o(max_err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  err;
    logic [127:0] sq;
    logic [63:0]  abs_s;
    logic [31:0]  n;
    logic [31:0]  exact;
    logic [31:0]  hi;
    logic [32:0]  mx;
  } exp_t;

  exp_t sb_q[$];
  exp_t m;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m.err = '0; m.sq = '0; m.abs_s = '0; m.n = '0; m.exact = '0; m.hi = '0; m.mx = '0;
  endtask

  task automatic do_start(input logic [31:0] len);
    @(negedge clk);
    start    = 1'b1;
    test_len = len;
    in_valid = 1'b1;          // a beat coinciding with start must be dropped
    appr     = 32'h0000_0999;
    accu     = 32'h0000_0000;
    model_clear();
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    longint ea, eb, e, ae, ab;
    appr     = a;
    accu     = b;
    in_valid = 1'b1;
    for (int w = 0; w < 16 && !in_ready; w++) @(negedge clk);
    check("ready_wait", {127'd0, in_ready}, 128'd1);
    ea = longint'($signed(a));
    eb = longint'($signed(b));
    e  = ea - eb;
    ae = (e < 0) ? -e : e;
    ab = (eb < 0) ? -eb : eb;
    m.err   = m.err + 64'(e);
    m.sq    = m.sq + 128'(ae) * 128'(ae);
    m.abs_s = m.abs_s + 64'(ab);
    m.n     = m.n + 1;
    if (a == b) m.exact = m.exact + 1;
    if (a[31:8] == b[31:8]) m.hi = m.hi + 1;
    if (33'(ae) > m.mx) m.mx = 33'(ae);
    @(negedge clk);
  endtask

  task automatic push_run();
    sb_q.push_back(m);
  endtask

  task automatic wait_and_compare();
    exp_t x;
    logic [127:0] max64, max40;
    max64 = {64'd0, {64{1'b1}}};
    max40 = {88'd0, {40{1'b1}}};
    for (int w = 0; w < 16 && !(done && done_s); w++) @(negedge clk);
    check("done", {126'd0, done, done_s}, 128'd3);
    x = sb_q.pop_front();
    check("n_samples",   128'(n_samples), 128'(x.n));
    check("err_sum",     128'(err_sum),   128'(x.err));
    check("sq_sum_64",   128'(sq_sum),    (x.sq > max64) ? max64 : x.sq);
    check("sq_sum_40",   128'(sq_sum_s),  (x.sq > max40) ? max40 : x.sq);
    check("abs_sum",     128'(abs_sum),   128'(x.abs_s));
    check("n_exact",     128'(n_exact),   128'(x.exact));
    check("n_hi_match",  128'(n_hi),      128'(x.hi));
    check("max_abs_err", 128'(max_err),   128'(x.mx));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready_done"}, {126'd0, in_ready, done}, 128'd0);
    check({tag, "_counts"},     {32'd0, n_samples, n_exact, n_hi}, 128'd0);
    check({tag, "_sums"},       {err_sum, sq_sum | abs_sum}, 128'd0);
    check({tag, "_max"},        128'(max_err), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; test_len = '0; in_valid = 1'b0; appr = '0; accu = '0;
    model_clear();

    // 1: reset state, then a zero-length run
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    do_start(32'd0);
    check("len0_done_next", {127'd0, done}, 128'd1);
    push_run();
    wait_and_compare();

    // 2: four back-to-back beats, done exactly two cycles after the last accept
    do_start(32'd4);
    send(32'd10, 32'd10);
    send(32'd12, 32'd10);
    send(32'd5,  32'd9);
    send(32'hFFFF_FFFD, 32'hFFFF_FFFD);
    in_valid = 1'b0;
    check("done_low_1_after", {127'd0, done}, 128'd0);
    @(negedge clk);
    check("done_high_2_after", {127'd0, done}, 128'd1);
    push_run();
    wait_and_compare();

    // 3: high-bit match vs exact match at ER_THRESH = 8
    do_start(32'd2);
    send(32'h1234_5601, 32'h1234_5600);
    send(32'h1234_5700, 32'h1234_5600);
    in_valid = 1'b0;
    push_run();
    wait_and_compare();

    // 4: extreme operands; single beat fits 64 bits exactly, four beats saturate
    do_start(32'd1);
    send(32'h7FFF_FFFF, 32'h8000_0000);
    in_valid = 1'b0;
    push_run();
    wait_and_compare();
    do_start(32'd4);
    for (int i = 0; i < 4; i++) send(32'h7FFF_FFFF, 32'h8000_0000);
    in_valid = 1'b0;
    push_run();
    wait_and_compare();

    // 5: gapped valid, then extra valid beats after the run is full
    do_start(32'd3);
    send(32'd100, 32'd97);
    in_valid = 1'b0; @(negedge clk);
    send(32'hFFFF_FF00, 32'd50);
    in_valid = 1'b0; @(negedge clk);
    send(32'd8, 32'd20);
    check("ready_low_after_last", {127'd0, in_ready}, 128'd0);
    appr = 32'h0100_0000; accu = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ready_low_extra", {127'd0, in_ready}, 128'd0);
    end
    in_valid = 1'b0;
    push_run();
    wait_and_compare();

    // 6: reset mid-run discards everything, then a fresh single-sample run
    do_start(32'd5);
    send(32'd20, 32'd3);
    send(32'd1, 32'd9);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    do_start(32'd1);
    send(32'd7, 32'd4);
    in_valid = 1'b0;
    push_run();
    wait_and_compare();

    check("scoreboard_empty", 128'(sb_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
